// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Optional alignment fault logic is enabled with `define FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;
    localparam int PC_STEP    = 4;
    localparam int BUF_DEPTH  = 2;

    // FETCH: nothing outstanding; WAIT: result wanted; DROP: result discarded
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, execute (redirect)
// and the decoder.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The producer holds valid and payload stable until that edge; ready may
    // depend on valid. imem_rsp_valid has no ready: the fetch unit always takes it.
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid,
               inst_data, inst_pc, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid,
               inst_data, inst_pc, fetch_fault
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO; slot 0 is always the head, so the head output keeps
// its last value once the buffer empties. Flush dominates push and pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_slot0;
    logic [W-1:0] r_slot1;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= i_data;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_slot1 <= i_data;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                    end
                    if (r_count != 2'd0) begin
                        r_count <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy unchanged, order kept
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= i_data;
                    end else begin
                        r_slot0 <= i_data;
                        r_count <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_slot0;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_flush && r_count == 2'(BUF_DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer to decode,
// redirect flush. `define FETCH_ALIGN_CHECK_EN enables the sticky alignment fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output fetch_state_e o_dbg_state
);

    fetch_state_e        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_req_pc;

    logic [ADDR_W-1:0]   w_redirect_pc;
    logic                w_fault;
    logic                w_req_valid;
    logic                w_req_fire;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_count;
    logic [ADDR_W+INST_W-1:0] w_head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    assign w_redirect_pc = bus.redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    assign w_redirect_pc = bus.redirect_pc & ~ADDR_W'(PC_STEP - 1);
    assign w_fault       = 1'b0;
`endif

    // Credit: never issue unless the buffer can take the eventual response
    assign w_req_valid = rst_n && (r_state == FETCH) && (w_count != 2'(BUF_DEPTH))
                         && !bus.redirect_valid && !w_fault;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_push      = (r_state == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    assign w_pop       = (w_count != 2'd0) && bus.inst_ready && !bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_req_fire) begin
                r_pc     <= r_pc + ADDR_W'(PC_STEP);
                r_req_pc <= r_pc;
            end

            case (r_state)
                FETCH: begin
                    if (w_req_fire) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_state <= FETCH;
                    end else if (bus.redirect_valid) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_rsp_valid) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    fetch_buffer #(
        .W (ADDR_W + INST_W)
    ) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  ({r_req_pc, bus.imem_rsp_data}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (w_count != 2'd0);
    assign bus.inst_pc        = w_head[ADDR_W+INST_W-1:INST_W];
    assign bus.inst_data      = w_head[INST_W-1:0];
    assign bus.fetch_fault    = w_fault;
    assign o_dbg_state        = r_state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Holds the PC and issues word requests to instruction memory, one outstanding at a time. Queues returned words with their PC in a 2-entry buffer, presented to decode over a valid/ready handshake. Accepts redirects (branch/jump) from execute, flushing in-flight and buffered work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; must be word aligned.
ADDR_W, 32, PC / memory address width.
INST_W, 32, instruction width; decoder field layout is fixed to 32 bits.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  reset; asynchronous, active-low.
redirect_valid  in  1  load redirect_pc this cycle; highest priority.
redirect_pc  in  ADDR_W  new fetch address.
imem_req_valid  out  1  request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  ADDR_W  word address (equals PC).
imem_rsp_valid  in  1  response data valid; exactly one per accepted request, any latency >=1 cycle.
imem_rsp_data  in  INST_W  returned instruction.
inst_valid  out  1  buffer head valid, to decoder.
inst_ready  in  1  decoder consumes head.
inst_data  out  INST_W  instruction to decoder (opcode in [3:0], reg_d [8:4], reg_b [13:9], reg_a [18:14], offset [31:19]).
inst_pc  out  ADDR_W  PC of inst_data.
fetch_fault  out  1  sticky fault flag (see Optional Feature); 0 when feature absent.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, buffer empty, outstanding=0, fetch_fault=0. Outputs: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- States: FETCH (no request outstanding), WAIT (request outstanding, result wanted), DROP (request outstanding, result discarded).
- imem_req_valid = (state==FETCH) && (count<2) && !redirect_valid && !fetch_fault; imem_req_addr = pc. Addr stable while valid and not ready.
- FETCH: on req handshake: req_pc<=pc, pc<=pc+4 (mod 2^ADDR_W; 0xFFFF_FFFC wraps to 0), ->WAIT.
- WAIT: on imem_rsp_valid push {req_pc, imem_rsp_data}, ->FETCH. Peak throughput 1 instruction / 2 cycles; first request cycle is the first clk edge after rst_n rises.
- Redirect (any state): pc<=redirect_pc; buffer flushed (count=0); pop ignored that cycle. FETCH->FETCH (no request issued that cycle). WAIT without rsp_valid->DROP. WAIT with rsp_valid same cycle: response discarded, ->FETCH. DROP->DROP.
- DROP: on imem_rsp_valid discard data, ->FETCH. A redirect arriving in DROP only updates pc.
- Buffer: 2-entry FIFO, head drives inst_*; inst_valid = count!=0. Push and pop same cycle: count unchanged, order preserved. Credit rule (count<2 at issue) guarantees no push when full; push into full buffer is an assertion failure.
- inst_data/inst_pc hold their last value when empty; hold stable while inst_valid && !inst_ready.
- Reset mid-operation: immediate return to reset values; outstanding memory response after reset is not expected (memory shares rst_n).

Optional Feature:
FETCH_ALIGN_CHECK_EN. Defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset), flushes buffer, stops issuing requests; any outstanding response is dropped. Undefined: redirect_pc[1:0] forced to 2'b00, fetch_fault tied 0.

Decomposition:
- fetch_pkg: ADDR_W/INST_W defaults, PC_STEP=4, state enum (FETCH, WAIT, DROP), buffer entry typedef {pc, inst}, BUF_DEPTH=2.
- Sub-module fetch_buffer: 2-entry FIFO with push, pop, flush, count, head outputs; flush dominates push/pop.

Test Plan:
- Reset RESET_PC=0x100, ready=1, rsp latency 1, inst_ready=1 -> requests 0x100, 0x104, 0x108 on every other cycle; inst_pc follows in order with matching data.
- inst_ready=0 -> exactly 2 requests issued (0x0, 0x4), then req_valid stays 0; inst_ready=1 -> drains in order, fetch resumes at 0x8.
- Redirect to 0x200 during WAIT (latency 5) -> stale response dropped, next request 0x200, no stale inst_valid.
- Redirect same cycle as rsp_valid and inst_ready with 1 buffered -> buffer empty next cycle, next request at redirect_pc.
- Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x202 -> fetch_fault=1, no further requests until rst_n pulse; without macro -> next request 0x200.
